// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, one bit per clock.
// Produces {borrow, (A-B) mod 2^SIZE} after SIZE run cycles, with a start/busy/done handshake.
module serial_subtractor #(
   parameter int unsigned SIZE = 4
) (
   input  logic            i_CLK,
   input  logic            i_RST,
   input  logic            i_START,
   input  logic [SIZE-1:0] i_VECTOR_ONE,
   input  logic [SIZE-1:0] i_VECTOR_TWO,
   output logic            o_BUSY,
   output logic            o_DONE,
   output logic [SIZE:0]   o_VECTOR_DIFF
);

   localparam int unsigned CNT_W = $clog2(SIZE) + 1;

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   localparam logic [CNT_W-1:0] LastBit = CNT_W'(SIZE - 1);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   logic [0:0]      r_state;
   logic [SIZE-1:0] r_op_a;
   logic [SIZE-1:0] r_op_b;
   logic [SIZE-1:0] r_shift;
   logic [CNT_W-1:0] r_cnt;
   logic            r_borrow;
   logic            r_done;
   logic [SIZE:0]   r_diff;

   logic [0:0]      w_state_nxt;
   logic [SIZE-1:0] w_op_a_nxt;
   logic [SIZE-1:0] w_op_b_nxt;
   logic [SIZE-1:0] w_shift_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic            w_borrow_nxt;
   logic            w_done_nxt;
   logic [SIZE:0]   w_diff_nxt;

   logic            w_a_bit;
   logic            w_b_bit;
   logic            w_diff_bit;
   logic            w_borrow_out;
   logic            w_last;

   // Operands shift right each run cycle, so the active bit is always at index 0.
   assign w_a_bit      = r_op_a[0];
   assign w_b_bit      = r_op_b[0];
   assign w_diff_bit   = w_a_bit ^ w_b_bit ^ r_borrow;
   assign w_borrow_out = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_borrow);
   assign w_last       = (r_cnt == LastBit);

   always_comb begin
      w_state_nxt  = r_state;
      w_op_a_nxt   = r_op_a;
      w_op_b_nxt   = r_op_b;
      w_shift_nxt  = r_shift;
      w_cnt_nxt    = r_cnt;
      w_borrow_nxt = r_borrow;
      w_done_nxt   = 1'b0;
      w_diff_nxt   = r_diff;

      unique case (r_state)
         StIdle: begin
            if (i_START) begin
               w_state_nxt  = StRun;
               w_op_a_nxt   = i_VECTOR_ONE;
               w_op_b_nxt   = i_VECTOR_TWO;
               w_cnt_nxt    = '0;
               w_borrow_nxt = 1'b0;
            end
         end
         StRun: begin
            w_op_a_nxt   = r_op_a >> 1;
            w_op_b_nxt   = r_op_b >> 1;
            w_shift_nxt  = {w_diff_bit, r_shift[SIZE-1:1]};
            w_cnt_nxt    = r_cnt + CntOne;
            w_borrow_nxt = w_borrow_out;
            // Final bit goes straight to the output so the result lands on the same edge.
            if (w_last) begin
               w_state_nxt = StIdle;
               w_done_nxt  = 1'b1;
               w_diff_nxt  = {w_borrow_out, w_diff_bit, r_shift[SIZE-1:1]};
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         r_state  <= StIdle;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_shift  <= '0;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_done   <= 1'b0;
         r_diff   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_op_a   <= w_op_a_nxt;
         r_op_b   <= w_op_b_nxt;
         r_shift  <= w_shift_nxt;
         r_cnt    <= w_cnt_nxt;
         r_borrow <= w_borrow_nxt;
         r_done   <= w_done_nxt;
         r_diff   <= w_diff_nxt;
      end
   end

   assign o_BUSY        = (r_state == StRun);
   assign o_DONE        = r_done;
   assign o_VECTOR_DIFF = r_diff;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Sequential counterpart to the ripple-carry adder: computes the difference of two SIZE-bit unsigned vectors. It uses one full-subtractor bit cell, processing one bit per clock, LSB first. Result is SIZE+1 bits: borrow as MSB, giving the two's-complement value of A−B. It serves area-constrained datapaths that accept multi-cycle latency, using a start/busy/done handshake.

Parameters:
SIZE, 4, operand width in bits (legal range ≥ 2)

Ports:
i_CLK  input  1  clock, rising-edge active
i_RST  input  1  synchronous reset, active-high
i_START  input  1  request a new subtraction; sampled only in IDLE
i_VECTOR_ONE  input  SIZE  minuend A; captured on the accepting edge
i_VECTOR_TWO  input  SIZE  subtrahend B; captured on the accepting edge
o_BUSY  output  1  high while an operation is in progress
o_DONE  output  1  one-cycle pulse: o_VECTOR_DIFF has just been updated
o_VECTOR_DIFF  output  SIZE+1  {borrow, (A−B) mod 2^SIZE}; held between operations

Behaviour:
- Clock and reset: one clock, i_CLK. Reset is synchronous and active-high on i_RST, and overrides every other input.
- Reset values: state=IDLE, o_BUSY=0, o_DONE=0, o_VECTOR_DIFF=0. Internal operand registers, shift register, bit counter and borrow flop are all cleared.
- Reset mid-operation: the operation aborts, o_DONE does not pulse, and o_VECTOR_DIFF returns to 0.
- States: IDLE, RUN.
- IDLE:
  - If i_START=1 at edge k, capture A and B, clear borrow and counter, and go to RUN.
  - o_BUSY=1 after edge k.
- RUN: each edge processes bit i = counter.
  - d = a_i ^ b_i ^ br
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d shifts into the internal result shift register from the MSB side; counter increments.
- Completion: RUN covers edges k+1 … k+SIZE.
  - At edge k+SIZE, with the last bit (i=SIZE−1) processed, o_VECTOR_DIFF ← {br', d, shifted bits} and o_DONE ← 1.
  - Also at edge k+SIZE: o_BUSY ← 0 and state ← IDLE.
  - Latency: o_DONE is first visible SIZE edges after the accepting edge.
- o_DONE is high for exactly one cycle, then returns to 0.
- o_VECTOR_DIFF changes only at the completion edge or on reset. It is stable at all other times, including during a subsequent RUN.
- i_START while o_BUSY=1 is ignored. Operand changes during RUN have no effect.
- i_START=1 in the cycle o_DONE=1: state is already IDLE, so the request is accepted at that edge. Back-to-back operations therefore have no idle gap. o_DONE still falls at that edge.
- i_START held high continuously restarts immediately after each completion.
- Arithmetic: A, B are unsigned. o_VECTOR_DIFF[SIZE] = 1 iff A < B.
- The full SIZE+1-bit output equals A−B in two's complement. It wraps to 2^(SIZE+1)+A−B when A<B.
- The counter is ceil(log2(SIZE))+1 bits wide and does not wrap before SIZE.

Test Plan:
- Reset: assert i_RST for 2 cycles while i_START=1 → o_BUSY=0, o_DONE=0, o_VECTOR_DIFF=5'b00000. No operation starts.
- SIZE=4, A=9, B=3, pulse i_START at edge k:
  - o_BUSY high for edges k+1 … k+4.
  - o_DONE pulses once after edge k+4.
  - o_VECTOR_DIFF=5'b00110.
- SIZE=4, A=3, B=5 → o_VECTOR_DIFF=5'b11110 (borrow=1, −2).
- SIZE=4 boundary cases:
  - A=0, B=15 → 5'b10001.
  - A=15, B=15 → 5'b00000.
  - A=15, B=0 → 5'b01111.
- Handshake:
  - Pulse i_START mid-RUN with new operands → ignored; first result unchanged.
  - Assert i_START in the o_DONE cycle with A=7, B=2 → accepted with no gap; the second o_DONE arrives 4 edges later with 5'b00101.
  - o_VECTOR_DIFF holds the first result throughout the second RUN.
- Assert i_RST at RUN cycle 2 → o_DONE never pulses, o_VECTOR_DIFF=0, o_BUSY=0.
- Then start A=12, B=4 → correct 5'b01000.
